// File: rtl/laser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : laser_pkg
// Description : Shared constants, coordinate type, FSM encoding and distance
//               helper for the laser host.
// Revision    : 1.0 - initial release
// ============================================================================
package laser_pkg;

   localparam int NUM_PTS   = 40;
   localparam int RADIUS_SQ = 16;

   typedef logic [3:0] coord_t;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_STREAM    = 3'd1,
      ST_WAIT_DONE = 3'd2,
      ST_SCORE     = 3'd3,
      ST_REPORT    = 3'd4
   } state_t;

   // Squared absolute difference; the compare keeps 0/15 free of wrap.
   function automatic logic [7:0] sq_diff(input coord_t a, input coord_t b);
      logic [3:0] d;
      d = (a >= b) ? (a - b) : (b - a);
      return {4'd0, d} * {4'd0, d};
   endfunction

endpackage
`default_nettype wire

// File: rtl/laser_dist_chk.sv
`default_nettype none
// ============================================================================
// Module      : laser_dist_chk
// Description : Flags a point lying inside (or on) either of two circles.
// Revision    : 1.0 - initial release
// ============================================================================
module laser_dist_chk #(
   parameter int RADIUS_SQ = laser_pkg::RADIUS_SQ
) (
   input  logic [3:0] px,
   input  logic [3:0] py,
   input  logic [3:0] ax,
   input  logic [3:0] ay,
   input  logic [3:0] bx,
   input  logic [3:0] by,
   output logic       hit
);
   import laser_pkg::*;

   localparam logic [8:0] c_rsq = 9'(RADIUS_SQ);

   logic [8:0] w_da;
   logic [8:0] w_db;

   assign w_da = {1'b0, sq_diff(px, ax)} + {1'b0, sq_diff(py, ay)};
   assign w_db = {1'b0, sq_diff(px, bx)} + {1'b0, sq_diff(py, by)};
   assign hit  = (w_da <= c_rsq) || (w_db <= c_rsq);

endmodule
`default_nettype wire

// File: rtl/laser_host.sv
`default_nettype none
// ============================================================================
// Module      : laser_host
// Description : Streams stored points to the laser solver, waits for its
//               circle centres and scores how many points they cover.
//               Optional best-run tracking: LASER_HOST_BEST_TRACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module laser_host #(
   parameter int NUM_PTS     = laser_pkg::NUM_PTS,
   parameter int RADIUS_SQ   = laser_pkg::RADIUS_SQ,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       LD_VALID,
   input  logic [5:0] LD_ADDR,
   input  logic [3:0] LD_X,
   input  logic [3:0] LD_Y,
   input  logic       START,
   output logic [3:0] X,
   output logic [3:0] Y,
   input  logic [3:0] C1X,
   input  logic [3:0] C1Y,
   input  logic [3:0] C2X,
   input  logic [3:0] C2Y,
   input  logic       DONE,
   output logic       BUSY,
   output logic       RESULT_VALID,
   output logic [5:0] COVER,
   output logic [3:0] R1X,
   output logic [3:0] R1Y,
   output logic [3:0] R2X,
   output logic [3:0] R2Y,
   output logic       TIMEOUT
`ifdef LASER_HOST_BEST_TRACK_EN
   ,
   output logic [5:0] BEST_COVER,
   output logic       BEST_NEW
`endif
);
   import laser_pkg::*;

   localparam int              TW        = $clog2(TIMEOUT_CYC + 1);
   localparam logic [5:0]      c_last    = 6'(NUM_PTS - 1);
   localparam logic [TW-1:0]   c_to_last = TW'(TIMEOUT_CYC - 1);

   coord_t        r_mem_x [0:NUM_PTS-1];
   coord_t        r_mem_y [0:NUM_PTS-1];
   state_t        r_state;
   logic [5:0]    r_idx;
   logic [TW-1:0] r_wait;
   coord_t        r_x, r_y, r_r1x, r_r1y, r_r2x, r_r2y;
   logic          r_busy, r_result_valid, r_timeout;
   logic [5:0]    r_cover;
   logic          w_ld_ok, w_fwd0, w_hit;
   logic [5:0]    w_cover_nxt;
`ifdef LASER_HOST_BEST_TRACK_EN
   logic [5:0]    r_best;
   logic          r_best_new;
`endif

   // Writes only land in IDLE so the memory is frozen for a whole run.
   assign w_ld_ok     = LD_VALID && (LD_ADDR <= c_last) && (r_state == ST_IDLE);
   assign w_fwd0      = w_ld_ok && (LD_ADDR == 6'd0);
   assign w_cover_nxt = r_cover + {5'd0, w_hit};

   always_ff @(posedge CLK) begin
      if (w_ld_ok) begin
         r_mem_x[LD_ADDR] <= LD_X;
         r_mem_y[LD_ADDR] <= LD_Y;
      end
   end

   laser_dist_chk #(.RADIUS_SQ(RADIUS_SQ)) u_dist (
      .px (r_mem_x[r_idx]),
      .py (r_mem_y[r_idx]),
      .ax (r_r1x),
      .ay (r_r1y),
      .bx (r_r2x),
      .by (r_r2y),
      .hit(w_hit)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state        <= ST_IDLE;
         r_idx          <= 6'd0;
         r_wait         <= '0;
         r_x            <= 4'd0;
         r_y            <= 4'd0;
         r_r1x          <= 4'd0;
         r_r1y          <= 4'd0;
         r_r2x          <= 4'd0;
         r_r2y          <= 4'd0;
         r_busy         <= 1'b0;
         r_result_valid <= 1'b0;
         r_timeout      <= 1'b0;
         r_cover        <= 6'd0;
`ifdef LASER_HOST_BEST_TRACK_EN
         r_best         <= 6'd0;
         r_best_new     <= 1'b0;
`endif
      end else begin
         r_result_valid <= 1'b0;
`ifdef LASER_HOST_BEST_TRACK_EN
         r_best_new     <= 1'b0;
`endif
         case (r_state)
            ST_IDLE: begin
               if (START) begin
                  // Forward a same-cycle write to point 0 into the first beat.
                  r_state <= ST_STREAM;
                  r_busy  <= 1'b1;
                  r_idx   <= 6'd0;
                  r_x     <= w_fwd0 ? LD_X : r_mem_x[0];
                  r_y     <= w_fwd0 ? LD_Y : r_mem_y[0];
               end
            end
            ST_STREAM: begin
               if (r_idx == c_last) begin
                  r_state <= ST_WAIT_DONE;
                  r_idx   <= 6'd0;
                  r_wait  <= '0;
                  r_x     <= 4'd0;
                  r_y     <= 4'd0;
               end else begin
                  r_idx <= r_idx + 6'd1;
                  r_x   <= r_mem_x[r_idx + 6'd1];
                  r_y   <= r_mem_y[r_idx + 6'd1];
               end
            end
            ST_WAIT_DONE: begin
               if (DONE) begin
                  r_state   <= ST_SCORE;
                  r_r1x     <= C1X;
                  r_r1y     <= C1Y;
                  r_r2x     <= C2X;
                  r_r2y     <= C2Y;
                  r_timeout <= 1'b0;
                  r_cover   <= 6'd0;
                  r_idx     <= 6'd0;
               end else if (r_wait == c_to_last) begin
                  r_state        <= ST_REPORT;
                  r_timeout      <= 1'b1;
                  r_cover        <= 6'd0;
                  r_result_valid <= 1'b1;
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
            end
            ST_SCORE: begin
               r_cover <= w_cover_nxt;
               if (r_idx == c_last) begin
                  r_state        <= ST_REPORT;
                  r_result_valid <= 1'b1;
`ifdef LASER_HOST_BEST_TRACK_EN
                  if (w_cover_nxt > r_best) begin
                     r_best     <= w_cover_nxt;
                     r_best_new <= 1'b1;
                  end
`endif
               end else begin
                  r_idx <= r_idx + 6'd1;
               end
            end
            ST_REPORT: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign X            = r_x;
   assign Y            = r_y;
   assign BUSY         = r_busy;
   assign RESULT_VALID = r_result_valid;
   assign COVER        = r_cover;
   assign R1X          = r_r1x;
   assign R1Y          = r_r1y;
   assign R2X          = r_r2x;
   assign R2Y          = r_r2y;
   assign TIMEOUT      = r_timeout;
`ifdef LASER_HOST_BEST_TRACK_EN
   assign BEST_COVER   = r_best;
   assign BEST_NEW     = r_best_new;
`endif

endmodule
`default_nettype wire

// File: tb/tb_laser_host.sv
`default_nettype none
// ============================================================================
// Module      : tb_laser_host
// Description : Self-checking bench for laser_host against a point-list model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_laser_host;
   localparam int N   = 40;
   localparam int TO  = 64;
   localparam int RSQ = 16;

   logic       CLK = 1'b0, RST = 1'b0;
   logic       LD_VALID = 1'b0, START = 1'b0, DONE = 1'b0;
   logic [5:0] LD_ADDR = 6'd0;
   logic [3:0] LD_X = 4'd0, LD_Y = 4'd0;
   logic [3:0] C1X = 4'd0, C1Y = 4'd0, C2X = 4'd0, C2Y = 4'd0;
   logic [3:0] X, Y, R1X, R1Y, R2X, R2Y;
   logic       BUSY, RESULT_VALID, TIMEOUT;
   logic [5:0] COVER;
`ifdef LASER_HOST_BEST_TRACK_EN
   logic [5:0] BEST_COVER, bc_seen;
   logic       BEST_NEW, bn_seen;
`endif

   int checks = 0, failures = 0;
   int ref_x [N];
   int ref_y [N];

   laser_host #(.NUM_PTS(N), .RADIUS_SQ(RSQ), .TIMEOUT_CYC(TO)) dut (
      .CLK(CLK), .RST(RST), .LD_VALID(LD_VALID), .LD_ADDR(LD_ADDR),
      .LD_X(LD_X), .LD_Y(LD_Y), .START(START), .X(X), .Y(Y),
      .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y), .DONE(DONE),
      .BUSY(BUSY), .RESULT_VALID(RESULT_VALID), .COVER(COVER),
      .R1X(R1X), .R1Y(R1Y), .R2X(R2X), .R2Y(R2Y), .TIMEOUT(TIMEOUT)
`ifdef LASER_HOST_BEST_TRACK_EN
      , .BEST_COVER(BEST_COVER), .BEST_NEW(BEST_NEW)
`endif
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Count of points within either circle, straight from the point list.
   function automatic int ref_cover(input int ax, input int ay, input int bx, input int by);
      int c = 0;
      for (int i = 0; i < N; i++) begin
         int da = (ref_x[i] - ax) ** 2 + (ref_y[i] - ay) ** 2;
         int db = (ref_x[i] - bx) ** 2 + (ref_y[i] - by) ** 2;
         if (da <= RSQ || db <= RSQ) c++;
      end
      return c;
   endfunction

   task automatic load_pt(input int a, input int x, input int y);
      LD_VALID = 1'b1; LD_ADDR = 6'(a); LD_X = 4'(x); LD_Y = 4'(y);
      @(negedge CLK);
      LD_VALID = 1'b0;
      if (a < N) begin ref_x[a] = x; ref_y[a] = y; end
   endtask

   // One full run; starts and ends right after a falling edge.
   task automatic run_once(input int dly, input int c1x, input int c1y,
                           input int c2x, input int c2y, input bit exp_to, input bit poke);
      int exp_cov, n, exp_lat;
      exp_cov = exp_to ? 0 : ref_cover(c1x, c1y, c2x, c2y);
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0; LD_VALID = 1'b0;
      for (int k = 0; k < N; k++) begin
         checks++;
         if (X !== 4'(ref_x[k]) || Y !== 4'(ref_y[k]) || BUSY !== 1'b1) begin
            failures++;
            $display("FAIL stream k=%0d: got X=%0d Y=%0d BUSY=%b, expected X=%0d Y=%0d BUSY=1",
                     k, X, Y, BUSY, ref_x[k], ref_y[k]);
         end
         DONE = (poke && k == 5);
         @(negedge CLK);
         DONE = 1'b0;
      end
      checks++;
      if (X !== 4'd0 || Y !== 4'd0) begin
         failures++;
         $display("FAIL stream_end_zero: got X=%0d Y=%0d, expected 0 0", X, Y);
      end
      if (!exp_to) begin
         for (int i = 0; i < dly; i++) begin
            if (poke && i == 2) begin
               START = 1'b1; LD_VALID = 1'b1; LD_ADDR = 6'd0;
               LD_X = ~4'(ref_x[0]); LD_Y = ~4'(ref_y[0]);
            end
            @(negedge CLK);
            START = 1'b0; LD_VALID = 1'b0;
         end
         C1X = 4'(c1x); C1Y = 4'(c1y); C2X = 4'(c2x); C2Y = 4'(c2y); DONE = 1'b1;
         @(negedge CLK);
         DONE = 1'b0;
         C1X = 4'($urandom); C1Y = 4'($urandom); C2X = 4'($urandom); C2Y = 4'($urandom);
      end
      n = 0;
      while (RESULT_VALID !== 1'b1 && n < 300) begin
         n++;
         @(negedge CLK);
      end
      exp_lat = exp_to ? TO : N;
      checks++;
      if (n !== exp_lat) begin
         failures++;
         $display("FAIL result_latency: got %0d cycles, expected %0d", n, exp_lat);
      end
      checks++;
      if (COVER !== 6'(exp_cov) || TIMEOUT !== exp_to) begin
         failures++;
         $display("FAIL cover: got COVER=%0d TIMEOUT=%b, expected COVER=%0d TIMEOUT=%b",
                  COVER, TIMEOUT, exp_cov, exp_to);
      end
      if (!exp_to) begin
         checks++;
         if (R1X !== 4'(c1x) || R1Y !== 4'(c1y) || R2X !== 4'(c2x) || R2Y !== 4'(c2y)) begin
            failures++;
            $display("FAIL centres: got (%0d,%0d)(%0d,%0d), expected (%0d,%0d)(%0d,%0d)",
                     R1X, R1Y, R2X, R2Y, c1x, c1y, c2x, c2y);
         end
      end
`ifdef LASER_HOST_BEST_TRACK_EN
      bn_seen = BEST_NEW;
      bc_seen = BEST_COVER;
`endif
      @(negedge CLK);
      checks++;
      if (RESULT_VALID !== 1'b0 || BUSY !== 1'b0 || COVER !== 6'(exp_cov)) begin
         failures++;
         $display("FAIL rv_pulse: got RV=%b BUSY=%b COVER=%0d, expected RV=0 BUSY=0 COVER=%0d",
                  RESULT_VALID, BUSY, COVER, exp_cov);
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      checks++;
      if (X !== 4'd0 || Y !== 4'd0 || BUSY !== 1'b0 || RESULT_VALID !== 1'b0 ||
          COVER !== 6'd0 || TIMEOUT !== 1'b0 || R1X !== 4'd0 || R2Y !== 4'd0) begin
         failures++;
         $display("FAIL reset_state: got X=%0d Y=%0d BUSY=%b RV=%b COVER=%0d TO=%b R1X=%0d R2Y=%0d, expected all 0",
                  X, Y, BUSY, RESULT_VALID, COVER, TIMEOUT, R1X, R2Y);
      end
      RST = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_uniform();
      for (int i = 0; i < N; i++) load_pt(i, 8, 8);
      run_once(10, 8, 8, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_boundary();
      for (int i = 0; i < N; i++) load_pt(i, 8, 8);
      load_pt(0, 0, 0);
      load_pt(1, 15, 15);
      run_once(4, 2, 2, 13, 13, 1'b0, 1'b0);
      run_once(0, 5, 0, 15, 10, 1'b0, 1'b0);
      load_pt(0, 4, 4);
      load_pt(1, 12, 12);
      run_once(1, 4, 4, 4, 4, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      for (int r = 0; r < 5; r++) begin
         int p, q;
         for (int i = 0; i < N; i++) load_pt(i, $urandom_range(0, 15), $urandom_range(0, 15));
         p = $urandom_range(0, N - 1);
         q = $urandom_range(0, N - 1);
         run_once($urandom_range(0, 30), ref_x[p], ref_y[p],
                  $urandom_range(0, 15), ref_y[q], 1'b0, 1'b0);
      end
   endtask

   task automatic test_timeout();
      run_once(0, 0, 0, 0, 0, 1'b1, 1'b0);
   endtask

   task automatic test_load_start_same_cycle();
      load_pt(45, 1, 1);
      LD_VALID = 1'b1; LD_ADDR = 6'd0; LD_X = 4'd3; LD_Y = 4'd12;
      ref_x[0] = 3; ref_y[0] = 12;
      run_once(2, 3, 12, 15, 0, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_once(6, 7, 9, 1, 14, 1'b0, 1'b1);
      run_once(3, 0, 15, 15, 0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid_stream();
      load_pt(20, 9, 6);
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      repeat (20) @(negedge CLK);
      checks++;
      if (X !== 4'd9 || Y !== 4'd6) begin
         failures++;
         $display("FAIL pre_reset_k20: got X=%0d Y=%0d, expected 9 6", X, Y);
      end
      RST = 1'b1;
      #1;
      checks++;
      if (X !== 4'd0 || Y !== 4'd0 || BUSY !== 1'b0 || COVER !== 6'd0 || R1X !== 4'd0) begin
         failures++;
         $display("FAIL async_reset: got X=%0d Y=%0d BUSY=%b COVER=%0d R1X=%0d, expected all 0",
                  X, Y, BUSY, COVER, R1X);
      end
      @(negedge CLK);
      RST = 1'b0;
      begin
         int rv_cnt = 0;
         for (int i = 0; i < 120; i++) begin
            if (RESULT_VALID === 1'b1 || BUSY === 1'b1) rv_cnt++;
            @(negedge CLK);
         end
         checks++;
         if (rv_cnt !== 0) begin
            failures++;
            $display("FAIL abort_no_result: got %0d active cycles after reset, expected 0", rv_cnt);
         end
      end
   endtask

`ifdef LASER_HOST_BEST_TRACK_EN
   task automatic test_best();
      int exp_bc [3] = '{30, 30, 35};
      int exp_bn [3] = '{1, 0, 1};
      int hits   [3] = '{30, 25, 35};
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < N; i++) begin
            if (i < hits[r]) load_pt(i, 8, 8);
            else load_pt(i, 0, 15);
         end
         run_once(5, 8, 8, 8, 8, 1'b0, 1'b0);
         checks++;
         if (bc_seen !== 6'(exp_bc[r]) || bn_seen !== 1'(exp_bn[r])) begin
            failures++;
            $display("FAIL best run=%0d: got BEST_COVER=%0d BEST_NEW=%b, expected %0d %0d",
                     r, bc_seen, bn_seen, exp_bc[r], exp_bn[r]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_uniform();
      test_boundary();
      test_random();
      test_timeout();
      test_load_start_same_cycle();
      test_back_to_back();
      test_reset_mid_stream();
`ifdef LASER_HOST_BEST_TRACK_EN
      test_best();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
